// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP types and constants for the FP execute stages
//
// Contents:
//   FP_W, FP_EXP_MAX : single-precision word width and all-ones exponent
//   fp_op_e          : add / subtract selector
//   fp_flags_t       : {nan, inf, zero} result classification
package fp_pkg;

  localparam int         FP_W       = 32;
  localparam logic [7:0] FP_EXP_MAX = 8'hFF;

  typedef enum logic {
    FP_ADD = 1'b0,
    FP_SUB = 1'b1
  } fp_op_e;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } fp_flags_t;

endpackage

// File: rtl/fp_add.sv
// rtl/fp_add.sv - combinational single-precision adder, round-to-nearest-even
//
// Ports:
//   i_a, i_b : IEEE-754 single-precision operands
//   o_sum    : a + b; NaN results are the canonical quiet NaN 0x7FC00000
module fp_add
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] i_a,
  input  logic [FP_W-1:0] i_b,
  output logic [FP_W-1:0] o_sum
);

  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_swap, w_eff_sub, w_up;
  logic [31:0] w_big, w_small;
  logic [7:0]  w_e_big, w_e_small, w_d;
  logic [26:0] w_mx, w_my_full, w_my, w_lost, w_norm;
  logic [27:0] w_raw;
  logic [8:0]  w_exp, w_exp_f;
  logic [4:0]  w_lz, w_sh;
  logic [24:0] w_mr;
  logic [22:0] w_mant_f;

  assign w_a_nan = (i_a[30:23] == FP_EXP_MAX) && (i_a[22:0] != 23'd0);
  assign w_b_nan = (i_b[30:23] == FP_EXP_MAX) && (i_b[22:0] != 23'd0);
  assign w_a_inf = (i_a[30:23] == FP_EXP_MAX) && (i_a[22:0] == 23'd0);
  assign w_b_inf = (i_b[30:23] == FP_EXP_MAX) && (i_b[22:0] == 23'd0);

  // Order by magnitude so alignment always shifts the smaller operand
  // and the result sign is the larger operand's sign.
  assign w_swap    = i_b[30:0] > i_a[30:0];
  assign w_big     = w_swap ? i_b : i_a;
  assign w_small   = w_swap ? i_a : i_b;
  assign w_eff_sub = w_big[31] ^ w_small[31];

  // Denormals behave as exponent 1 without the hidden bit.
  assign w_e_big   = (w_big[30:23]   == 8'd0) ? 8'd1 : w_big[30:23];
  assign w_e_small = (w_small[30:23] == 8'd0) ? 8'd1 : w_small[30:23];
  assign w_d       = w_e_big - w_e_small;

  // Mantissas carry three extra low bits: guard, round, sticky.
  assign w_mx      = {(w_big[30:23]   != 8'd0), w_big[22:0],   3'b000};
  assign w_my_full = {(w_small[30:23] != 8'd0), w_small[22:0], 3'b000};

  always_comb begin
    w_lost = '0;
    w_my   = '0;
    if (w_d >= 8'd27) begin
      w_my = {26'd0, |w_my_full};
    end else begin
      w_lost = w_my_full & ~({27{1'b1}} << w_d);
      w_my   = (w_my_full >> w_d) | {26'd0, |w_lost};
    end
  end

  assign w_raw = w_eff_sub ? ({1'b0, w_mx} - {1'b0, w_my})
                           : ({1'b0, w_mx} + {1'b0, w_my});

  always_comb begin
    w_lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (w_raw[i]) w_lz = 5'(26 - i);
    end
  end

  always_comb begin
    w_sh   = '0;
    w_norm = w_raw[26:0];
    w_exp  = {1'b0, w_e_big};
    if (w_raw[27]) begin
      w_norm = {w_raw[27:2], w_raw[1] | w_raw[0]};
      w_exp  = w_exp + 9'd1;
    end else begin
      // Left-normalise, but never below exponent 1: the rest stays denormal.
      w_sh   = ({4'd0, w_lz} < (w_exp - 9'd1)) ? w_lz : 5'(w_exp - 9'd1);
      w_norm = w_raw[26:0] << w_sh;
      w_exp  = w_exp - {4'd0, w_sh};
    end
  end

  assign w_up = w_norm[2] & (w_norm[3] | w_norm[1] | w_norm[0]);
  assign w_mr = {1'b0, w_norm[26:3]} + {24'd0, w_up};

  always_comb begin
    w_exp_f  = w_exp;
    w_mant_f = w_mr[22:0];
    if (w_mr[24]) begin
      w_exp_f  = w_exp + 9'd1;
      w_mant_f = w_mr[23:1];
    end
  end

  always_comb begin
    o_sum = '0;
    if (w_a_nan || w_b_nan)       o_sum = QNAN;
    else if (w_a_inf && w_b_inf)  o_sum = (i_a[31] != i_b[31]) ? QNAN : i_a;
    else if (w_a_inf)             o_sum = i_a;
    else if (w_b_inf)             o_sum = i_b;
    else if (w_raw == 28'd0)      o_sum = {~w_eff_sub & w_big[31], 31'd0};
    else if (w_exp_f >= 9'd255)   o_sum = {w_big[31], FP_EXP_MAX, 23'd0};
    else if (w_mr[24] | w_mr[23]) o_sum = {w_big[31], w_exp_f[7:0], w_mant_f};
    else                          o_sum = {w_big[31], 8'd0, w_mant_f};
  end

endmodule

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational nan/inf/zero classifier for a single-precision word
//
// Ports:
//   i_val   : IEEE-754 single-precision value
//   o_flags : {nan, inf, zero}; at most one bit is set
module fp_classify
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] i_val,
  output fp_flags_t       o_flags
);

  logic [7:0]  w_exp;
  logic [22:0] w_mant;
  logic        w_unused_sign;

  assign w_exp         = i_val[30:23];
  assign w_mant        = i_val[22:0];
  assign w_unused_sign = i_val[31];

  assign o_flags.nan  = (w_exp == FP_EXP_MAX) && (w_mant != 23'd0);
  assign o_flags.inf  = (w_exp == FP_EXP_MAX) && (w_mant == 23'd0);
  assign o_flags.zero = (w_exp == 8'd0)       && (w_mant == 23'd0);

endmodule

// File: rtl/fp_sub.sv
// rtl/fp_sub.sv - combinational single-precision subtractor (a - b)
//
// Ports:
//   i_a, i_b : IEEE-754 single-precision operands
//   o_diff   : a - b, computed as a + (-b)
module fp_sub
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] i_a,
  input  logic [FP_W-1:0] i_b,
  output logic [FP_W-1:0] o_diff
);

  logic [FP_W-1:0] w_b_neg;

  assign w_b_neg = {~i_b[FP_W-1], i_b[FP_W-2:0]};

  fp_add u_add (
    .i_a   (i_a),
    .i_b   (w_b_neg),
    .o_sum (o_diff)
  );

endmodule

// File: rtl/fp_addsub_stage.sv
// rtl/fp_addsub_stage.sv - two-register FP add/sub execute stage with valid/ready flow control
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   in_valid/in_ready       : issue handshake; in_op (0 add, 1 sub), in_a, in_b, in_tag
//   out_valid/out_ready     : writeback handshake; out_result, out_tag, out_flags {nan,inf,zero}
//   op_count                : completed output handshakes, wraps at 16 bits
module fp_addsub_stage
  import fp_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [FP_W-1:0]  in_a,
  input  logic [FP_W-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       out_flags,
  output logic [15:0]      op_count
);

  logic             r_s1_valid, r_s2_valid;
  fp_op_e           r_s1_op;
  logic [FP_W-1:0]  r_s1_a, r_s1_b, r_result;
  logic [TAG_W-1:0] r_s1_tag, r_tag;
  fp_flags_t        r_flags;
  logic [15:0]      r_op_count;

  logic [FP_W-1:0]  w_sum, w_diff, w_sel;
  fp_flags_t        w_sel_flags;
  logic             w_s1_adv, w_accept, w_consume;

  fp_add u_fadd (.i_a(r_s1_a), .i_b(r_s1_b), .o_sum(w_sum));
  fp_sub u_fsub (.i_a(r_s1_a), .i_b(r_s1_b), .o_diff(w_diff));

  assign w_sel = (r_s1_op == FP_SUB) ? w_diff : w_sum;

  fp_classify u_cls (.i_val(w_sel), .o_flags(w_sel_flags));

  // S1 moves on whenever S2 is empty or is being drained this cycle,
  // which lets S1 refill in the same cycle with no bubble.
  assign w_s1_adv  = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_s1_adv;
  assign w_accept  = in_valid && in_ready;
  assign w_consume = r_s2_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= FP_ADD;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_tag   <= '0;
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_tag      <= '0;
      r_flags    <= '0;
      r_op_count <= '0;
    end else begin
      if (w_accept) begin
        r_s1_op  <= fp_op_e'(in_op);
        r_s1_a   <= in_a;
        r_s1_b   <= in_b;
        r_s1_tag <= in_tag;
      end
      r_s1_valid <= w_accept || (r_s1_valid && !w_s1_adv);
      if (w_s1_adv) begin
        r_result <= w_sel;
        r_tag    <= r_s1_tag;
        r_flags  <= w_sel_flags;
      end
      r_s2_valid <= w_s1_adv || (r_s2_valid && !out_ready);
      if (w_consume) r_op_count <= r_op_count + 16'd1;
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_result;
  assign out_tag    = r_tag;
  assign out_flags  = r_flags;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_fp_addsub_stage.sv
// tb/tb_fp_addsub_stage.sv - randomized scoreboard bench for fp_addsub_stage
module tb_fp_addsub_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic [2:0]  out_flags;
  logic [15:0] op_count;

  logic bp_mode;
  logic dir_ready;
  logic rand_ready;

  assign out_ready = bp_mode ? rand_ready : dir_ready;

  always #5 clk = ~clk;

  fp_addsub_stage #(.TAG_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_flags  (out_flags),
    .op_count   (op_count)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          stamp;
  } exp_t;

  exp_t       q[$];
  logic [4:0] out_tags[$];
  int         cyc = 0;
  int         consumed = 0;
  int         tests = 0;
  int         fails = 0;
  int         stalls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [31:0] f);
    int  e, m;
    real v;
    e = int'({24'd0, f[30:23]});
    m = int'({9'd0, f[22:0]});
    if (e == 0) v = m * pow2(-149);
    else        v = (m + 8388608) * pow2(e - 150);
    return f[31] ? -v : v;
  endfunction

  // Rounds a double to the nearest single (ties to even).
  function automatic logic [31:0] r2f(input real x);
    logic [63:0] d, kept, rem, half, sig;
    logic        s;
    int          ue, be, drop;
    d = $realtobits(x);
    s = d[63];
    if (d[62:0] == 63'd0) return {s, 31'd0};
    ue   = int'({21'd0, d[62:52]}) - 1023;
    sig  = {11'd0, 1'b1, d[51:0]};
    be   = (ue < -126) ? -126 : ue;
    drop = 29 + (be - ue);
    if (drop > 60) return {s, 31'd0};
    kept = sig >> drop;
    rem  = sig & ((64'd1 << drop) - 64'd1);
    half = 64'd1 << (drop - 1);
    if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
    if (kept == (64'd1 << 24)) begin
      kept = kept >> 1;
      be   = be + 1;
    end
    if (kept >= (64'd1 << 23)) begin
      if (be + 127 >= 255) return {s, 8'hFF, 23'd0};
      return {s, 8'(be + 127), kept[22:0]};
    end
    return {s, 8'd0, kept[22:0]};
  endfunction

  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
  endfunction

  function automatic logic [2:0] ref_flags(input logic [31:0] f);
    return {is_nan(f), is_inf(f), f[30:0] == 31'd0};
  endfunction

  function automatic logic [31:0] ref_op(input logic op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] bb;
    bb = op ? {~b[31], b[30:0]} : b;
    if (is_nan(a) || is_nan(bb)) return 32'h7FC00000;
    if (is_inf(a) && is_inf(bb)) return (a[31] != bb[31]) ? 32'h7FC00000 : a;
    if (is_inf(a)) return a;
    if (is_inf(bb)) return bb;
    return r2f(f2r(a) + f2r(bb));
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : mon
    logic exp_valid;
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      consumed = 0;
    end else begin
      exp_valid = (q.size() > 0) && (cyc - q[0].stamp >= 2);
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      check("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2) || out_ready});
      check("op_count", {16'd0, op_count}, {16'd0, consumed[15:0]});
      if (out_valid && exp_valid) begin
        if (is_nan(q[0].res)) check("result_is_nan", {31'd0, is_nan(out_result)}, 32'd1);
        else                  check("result", out_result, q[0].res);
        check("tag", {27'd0, out_tag}, {27'd0, q[0].tag});
        check("flags", {29'd0, out_flags}, {29'd0, ref_flags(q[0].res)});
        if (out_ready) begin
          out_tags.push_back(out_tag);
          void'(q.pop_front());
          consumed++;
        end
      end
      if (in_valid && in_ready) begin
        e.res   = ref_op(in_op, in_a, in_b);
        e.tag   = in_tag;
        e.stamp = cyc;
        q.push_back(e);
      end
    end
  end

  always @(posedge clk) begin
    #1 rand_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- stimulus helpers ----------------
  // Called and returns at one time unit after a rising edge.
  task automatic send(input logic op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    int k;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k > 0) stalls++;
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", k);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    out_tags.delete();
  endtask

  task automatic single(input logic op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                        input logic [31:0] exp_res, input logic [2:0] exp_fl, input logic [15:0] exp_cnt);
    send(op, a, b, tag);
    check("lat_not_early", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("lat2_valid", {31'd0, out_valid}, 32'd1);
    if (exp_fl == 3'b001)      check("dir_zero", {1'b0, out_result[30:0]}, 32'd0);
    else if (exp_fl != 3'b100) check("dir_result", out_result, exp_res);
    check("dir_tag", {27'd0, out_tag}, {27'd0, tag});
    check("dir_flags", {29'd0, out_flags}, {29'd0, exp_fl});
    @(posedge clk);
    #1;
    check("dir_count", {16'd0, op_count}, {16'd0, exp_cnt});
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    int          sel;
    sel = int'($urandom_range(0, 31));
    r   = $urandom;
    if (sel == 0) return {r[31], 8'hFF, 23'd0};
    if (sel == 1) return {r[31], 8'hFF, r[22:0] | 23'd1};
    if (sel == 2) return {r[31], 31'd0};
    if (sel == 3) return {r[31], 8'd0, r[22:0]};
    if (sel == 4) return {r[31], 8'd254, r[22:0]};
    return {r[31], 8'(110 + $urandom_range(0, 34)), r[22:0]};
  endfunction

  function automatic logic [31:0] rand_b(input logic [31:0] a);
    logic [31:0] r;
    int          sel, e;
    sel = int'($urandom_range(0, 7));
    r   = $urandom;
    if (sel == 0) return a;
    if (sel <= 2 && a[30:23] > 8'd4 && a[30:23] < 8'd250) begin
      e = int'({24'd0, a[30:23]}) + int'($urandom_range(0, 6)) - 3;
      return {r[31], 8'(e), r[22:0]};
    end
    return rand_fp();
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    bp_mode   = 1'b0;
    dir_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_op_count", {16'd0, op_count}, 32'd0);
    check("rst_result", out_result, 32'd0);
    check("rst_tag", {27'd0, out_tag}, 32'd0);
    check("rst_flags", {29'd0, out_flags}, 32'd0);

    check("model_1p2", ref_op(1'b0, 32'h3F800000, 32'h40000000), 32'h40400000);
    check("model_3m1", ref_op(1'b1, 32'h40400000, 32'h3F800000), 32'h40000000);
    check("model_1m1", ref_op(1'b1, 32'h3F800000, 32'h3F800000), 32'h00000000);
    check("model_1p05", ref_op(1'b0, 32'h3F800000, 32'h3F000000), 32'h3FC00000);

    single(1'b0, 32'h3F800000, 32'h40000000, 5'd3, 32'h40400000, 3'b000, 16'd1);
    single(1'b1, 32'h3F800000, 32'h3F800000, 5'd4, 32'h00000000, 3'b001, 16'd2);
    single(1'b1, 32'h40400000, 32'h3F800000, 5'd5, 32'h40000000, 3'b000, 16'd3);
    single(1'b0, 32'h7F800000, 32'h3F800000, 5'd6, 32'h7F800000, 3'b010, 16'd4);
    single(1'b0, 32'h7FC00000, 32'h3F800000, 5'd7, 32'h7FC00000, 3'b100, 16'd5);

    // Backpressure: four ops while writeback stalls, then release.
    do_reset();
    dir_ready = 1'b0;
    stalls    = 0;
    fork
      begin
        for (int t = 0; t < 4; t++) send(1'b0, 32'h3F800000 + t, 32'h40000000, 5'(t));
      end
      begin
        repeat (6) @(posedge clk);
        #1 dir_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    check("bp_in_ready_fell", {31'd0, stalls > 0}, 32'd1);
    check("bp_tag_count", out_tags.size(), 32'd4);
    for (int t = 0; t < out_tags.size() && t < 4; t++) check("bp_tag_order", {27'd0, out_tags[t]}, t);
    check("bp_op_count", {16'd0, op_count}, 32'd4);

    // Full throughput with writeback always ready.
    do_reset();
    dir_ready = 1'b1;
    stalls    = 0;
    for (int t = 0; t < 8; t++) begin
      a = rand_fp();
      send(t[0], a, rand_b(a), 5'(t + 8));
    end
    repeat (3) @(posedge clk);
    #1;
    check("tp_no_stall", stalls, 32'd0);
    check("tp_op_count", {16'd0, op_count}, 32'd8);

    // Reset with both registers full.
    do_reset();
    dir_ready = 1'b0;
    send(1'b0, 32'h3F800000, 32'h3F800000, 5'd1);
    send(1'b0, 32'h40000000, 32'h3F800000, 5'd2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_op_count", {16'd0, op_count}, 32'd0);
    dir_ready = 1'b1;
    single(1'b0, 32'h40000000, 32'h40000000, 5'd9, 32'h40800000, 3'b000, 16'd1);

    // Randomized traffic with random writeback stalls.
    do_reset();
    bp_mode = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end
      a = rand_fp();
      send(1'(($urandom_range(0, 1))), a, rand_b(a), 5'($urandom_range(0, 31)));
    end
    bp_mode   = 1'b0;
    dir_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rand_drained", q.size(), 32'd0);
    check("rand_op_count", {16'd0, op_count}, 32'd300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fp_addsub_stage.md
# fp_addsub_stage

Pipelined, flow-controlled execute stage for floating-point add and subtract. It sits between FP issue and writeback. It registers the issued operands, drives the existing combinational FADD and FSUB blocks, selects the result by opcode, classifies it, and holds it in an output register under valid/ready backpressure. Sustained throughput is one operation per cycle; latency is fixed at 2 cycles.

## Interface
- `TAG_W`, default 5: width of the destination/ROB tag carried alongside each operation.
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `in_valid` in 1: issue presents an operation.
- `in_ready` out 1: the stage can accept an operation this cycle.
- `in_op` in 1: 0 = add, 1 = subtract (a − b).
- `in_a` in 32: IEEE-754 single-precision operand a.
- `in_b` in 32: IEEE-754 single-precision operand b.
- `in_tag` in TAG_W: tag carried unchanged to the output.
- `out_valid` out 1: the result register holds a valid result.
- `out_ready` in 1: writeback consumes the result.
- `out_result` out 32: sum or difference.
- `out_tag` out TAG_W: tag of the result.
- `out_flags` out 3: {nan, inf, zero} classification of `out_result`.
- `op_count` out 16: count of completed operations (handshakes on the output); wraps at 0xFFFF → 0.

## Operation
- **Accept:** an operation is accepted when `in_valid && in_ready`. The accepted op, a, b and tag are captured into S1 (operand register), and `s1_valid` is set.
- **Compute:** FADD(s1_a, s1_b) and FSUB(s1_a, s1_b) are evaluated combinationally from S1. The stage selects FSUB when `s1_op` = 1.
- **Advance:** the S1→S2 transfer fires when `s1_valid && (!s2_valid || out_ready)`. S2 captures the selected result, the tag, and the classification.
- **Classification** of the 32-bit result:
  - nan = exp==8'hFF && mant!=0
  - inf = exp==8'hFF && mant==0
  - zero = exp==0 && mant==0 (either sign)
  - At most one flag is set.
- **Input ready:** `in_ready = !s1_valid || s1_advance`. This is combinational from `out_ready`; there is no bubble under continuous flow.
- **Output handshake:**
  - `out_valid` = `s2_valid`.
  - On `out_valid && out_ready`, S2 is cleared unless it is refilled in the same cycle.
  - `op_count` increments by 1 on that cycle.
- **Simultaneous events:**
  - Output consume, S1→S2 advance and new accept can all occur in one cycle. S2 then takes the old S1, and S1 takes the new input.
- **Backpressure:**
  - While `out_ready` = 0 with S2 full, S1 holds.
  - Once S1 is also full, `in_ready` = 0.
  - Held registers must not change. `out_*` stays stable while `out_valid && !out_ready`.
- **Ordering:** results leave in acceptance order; none are dropped or duplicated.
- **Reset:**
  - `s1_valid`, `s2_valid`, `out_result`, `out_tag`, `out_flags` and `op_count` all go to 0.
  - `in_ready` = 1 in the first cycle after reset.
  - Operations in flight at reset are discarded silently.

## Timing
- Input accepted at edge N → `out_valid` = 1 after edge N+1, first visible in cycle N+2 (latency 2).
- Back-to-back accepts with `out_ready` held at 1 produce one result every cycle.
- `in_ready` depends combinationally on `out_ready`. `out_*` are driven only from registers.
- Capacity is 2 operations (S1 + S2).
- The FADD/FSUB path is a single-cycle combinational path from S1 to S2.

## Structure
- Package `fp_pkg`:
  - `fp_op_e` (FP_ADD=1'b0, FP_SUB=1'b1)
  - `fp_flags_t` packed struct {nan, inf, zero}
  - constants `FP_EXP_MAX`=8'hFF, `FP_W`=32
- Sub-module `fp_classify`: combinational, 32-bit in → `fp_flags_t`. It is reusable by other FP stages.
- The stage instantiates the existing FADD and FSUB blocks plus `fp_classify`. The rest is the S1/S2 registers and handshake logic in this module.

## Test plan
- **Add:** op=0, a=0x3F800000 (1.0), b=0x40000000 (2.0), tag=3 → cycle +2: `out_result`=0x40400000 (3.0), tag=3, flags=000; `op_count`=1 after the consume.
- **Subtract to zero:** op=1, a=b=0x3F800000 → `out_result` is a zero encoding (exp=0, mant=0), flags=001. Then op=1, a=0x40400000, b=0x3F800000 → 0x40000000.
- **Special values:**
  - op=0, a=0x7F800000 (inf), b=0x3F800000 → flags=010.
  - a=0x7FC00000 (NaN) → flags=100.
- **Backpressure:** 4 back-to-back ops, tags 0..3, with `out_ready`=0 for cycles 2..6:
  - `in_ready` falls once 2 ops are held.
  - Each held `out_*` stays stable while stalled.
  - After release, tags come out as 0,1,2,3 with no loss.
  - `op_count`=4.
- **Full throughput:** 8 consecutive ops with `out_ready`=1 → 8 results on 8 consecutive cycles, starting 2 cycles after the first accept; `in_ready` never deasserts.
- **Reset mid-flight:** assert `rst` with S1 and S2 both full:
  - Next cycle: `out_valid`=0, `in_ready`=1, `op_count`=0.
  - A new op then completes normally with latency 2.
